mult_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one 8-bit sequential signed multiplier among four requesters. It accepts per-requester operand pairs, grants the multiplier to one requester at a time, and drives the multiplier's start/done handshake. It returns the 16-bit product to the granted requester with a one-cycle done pulse, and bounds every operation with a timeout. It sits between the client blocks and the multiplier datapath.

---
 rtl/mult_arbiter.sv | 114 +++++++++++
 tb/tb_mult_arbiter.sv | 488 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_arbiter.sv
// mult_arbiter: round-robin arbiter sharing one sequential signed multiplier among four requesters.
// Owns the multiplier start/done handshake and aborts any operation that outlasts TIMEOUT.
module mult_arbiter #(
    parameter int TIMEOUT = 300
) (
    input  logic        CLK,
    input  logic        RSTn,
    input  logic [3:0]  Req_Sig,
    input  logic [31:0] Mcand_Bus,
    input  logic [31:0] Mer_Bus,
    output logic [3:0]  Grant,
    output logic [3:0]  Done_Sig,
    output logic [15:0] Product,
    output logic        Err_Sig,
    output logic        Busy,
    output logic        Mul_Start,
    output logic [7:0]  Mul_Mcand,
    output logic [7:0]  Mul_Mer,
    input  logic        Mul_Done,
    input  logic [15:0] Mul_Product
);
    localparam int CW = $clog2(TIMEOUT + 1);
    typedef enum logic [1:0] {IDLE, RUN, DONE, GAP} state_t;
    state_t        state_q, state_d;
    logic [3:0]    grant_q, grant_d;
    logic [1:0]    ptr_q, ptr_d, sel;
    logic [7:0]    mcand_q, mcand_d, mer_q, mer_d;
    logic [15:0]   product_q, product_d;
    logic          err_q, err_d, busy_q, busy_d, start_q, start_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          expired;
    // The counter holds 0 in the first RUN cycle, so the abort lands TIMEOUT+1 cycles after grant.
    assign expired = cnt_q == CW'(TIMEOUT);
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            ptr_q     <= 2'd3;
            mcand_q   <= '0;
            mer_q     <= '0;
            product_q <= '0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
            start_q   <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            ptr_q     <= ptr_d;
            mcand_q   <= mcand_d;
            mer_q     <= mer_d;
            product_q <= product_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
            start_q   <= start_d;
            cnt_q     <= cnt_d;
        end
    end
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = |Req_Sig ? RUN : IDLE;
            RUN:     state_d = (Mul_Done || expired) ? DONE : RUN;
            DONE:    state_d = GAP;
            default: state_d = IDLE;
        endcase
    end
    // Scan farthest-to-nearest from the pointer so the nearest asserted requester wins.
    always_comb begin
        sel = ptr_q;
        for (int i = 4; i >= 1; i--)
            if (Req_Sig[ptr_q + 2'(i)]) sel = ptr_q + 2'(i);
    end
    always_comb begin
        grant_d   = grant_q;
        ptr_d     = ptr_q;
        mcand_d   = mcand_q;
        mer_d     = mer_q;
        product_d = product_q;
        err_d     = err_q;
        start_d   = start_q;
        cnt_d     = (state_q == RUN) ? cnt_q + 1'b1 : cnt_q;
        busy_d    = state_d != IDLE;
        case (state_q)
            IDLE: if (|Req_Sig) begin
                grant_d = 4'b0001 << sel;
                ptr_d   = sel;
                mcand_d = Mcand_Bus[{sel, 3'b000} +: 8];
                mer_d   = Mer_Bus[{sel, 3'b000} +: 8];
                start_d = 1'b1;
                cnt_d   = '0;
            end
            RUN: if (Mul_Done || expired) begin
                product_d = Mul_Done ? Mul_Product : 16'h0000;
                err_d     = !Mul_Done;
            end
            DONE: start_d = 1'b0;
            default: begin
                grant_d = '0;
                err_d   = 1'b0;
            end
        endcase
    end
    always_comb begin
        Done_Sig = (state_q == DONE) ? grant_q : 4'b0000;
    end
    assign Grant     = grant_q;
    assign Product   = product_q;
    assign Err_Sig   = err_q;
    assign Busy      = busy_q;
    assign Mul_Start = start_q;
    assign Mul_Mcand = mcand_q;
    assign Mul_Mer   = mer_q;
endmodule

// File: tb/tb_mult_arbiter.sv
// tb_mult_arbiter: randomized scenarios against a behavioural arbitration/product model,
// with a behavioural sequential multiplier (random latency, optional never-done stub) attached.
module tb_mult_arbiter;
    localparam int TIMEOUT = 300;
    logic        CLK = 1'b0;
    logic        RSTn = 1'b0;
    logic [3:0]  Req_Sig = '0;
    logic [31:0] Mcand_Bus = '0;
    logic [31:0] Mer_Bus = '0;
    logic        Mul_Done = 1'b0;
    logic [15:0] Mul_Product = '0;
    logic [3:0]  Grant, Done_Sig;
    logic [15:0] Product;
    logic        Err_Sig, Busy, Mul_Start;
    logic [7:0]  Mul_Mcand, Mul_Mer;
    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int mdone_cyc = -100;
    int mul_cnt = 0;
    bit mul_active = 1'b0;
    bit mul_stub = 1'b0;
    int m_ptr = 3;
    logic [7:0] mc [4];
    logic [7:0] mr [4];

    mult_arbiter #(.TIMEOUT(TIMEOUT)) dut (
        .CLK(CLK), .RSTn(RSTn), .Req_Sig(Req_Sig), .Mcand_Bus(Mcand_Bus), .Mer_Bus(Mer_Bus),
        .Grant(Grant), .Done_Sig(Done_Sig), .Product(Product), .Err_Sig(Err_Sig), .Busy(Busy),
        .Mul_Start(Mul_Start), .Mul_Mcand(Mul_Mcand), .Mul_Mer(Mul_Mer),
        .Mul_Done(Mul_Done), .Mul_Product(Mul_Product)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc++;

    // Multiplier: starts on Mul_Start, returns after a random latency, idles when Mul_Start drops.
    always @(negedge CLK) begin
        Mul_Done = 1'b0;
        if (!Mul_Start) mul_active = 1'b0;
        else if (!mul_active) begin
            mul_active = 1'b1;
            mul_cnt = $urandom_range(1, 20);
        end else if (mul_cnt > 0) begin
            mul_cnt--;
            if (mul_cnt == 0 && !mul_stub) begin
                Mul_Done = 1'b1;
                Mul_Product = {{8{Mul_Mcand[7]}}, Mul_Mcand} * {{8{Mul_Mer[7]}}, Mul_Mer};
                mdone_cyc = cyc;
            end
        end
    end

    function automatic int pick(input int ptr, input logic [3:0] req);
        for (int i = 1; i <= 4; i++) if (req[(ptr + i) % 4]) return (ptr + i) % 4;
        return -1;
    endfunction

    function automatic logic [15:0] ref_prod(input logic [7:0] a, input logic [7:0] b);
        int p;
        p = int'($signed(a)) * int'($signed(b));
        return 16'(p);
    endfunction

    task automatic drive_bus();
        for (int k = 0; k < 4; k++) begin
            Mcand_Bus[8*k +: 8] = mc[k];
            Mer_Bus[8*k +: 8] = mr[k];
        end
    endtask

    task automatic wait_grant(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge CLK);
            ok = Grant !== 4'b0000;
        end
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge CLK);
            ok = Done_Sig !== 4'b0000;
        end
    endtask

    task automatic test_reset();
        for (int k = 0; k < 4; k++) begin
            mc[k] = 8'h00;
            mr[k] = 8'h00;
        end
        drive_bus();
        RSTn = 1'b0;
        Req_Sig = '0;
        m_ptr = 3;
        repeat (3) @(negedge CLK);
        checks++;
        if ({Grant, Done_Sig, Err_Sig, Busy, Mul_Start} !== 11'b0) begin
            failures++;
            $display("FAIL reset_ctrl: grant=%b done=%b err=%b busy=%b start=%b want all 0", Grant, Done_Sig, Err_Sig, Busy, Mul_Start);
        end
        checks++;
        if ({Product, Mul_Mcand, Mul_Mer} !== 32'h0) begin
            failures++;
            $display("FAIL reset_data: product=%h mcand=%h mer=%h want 0", Product, Mul_Mcand, Mul_Mer);
        end
        RSTn = 1'b1;
        repeat (2) @(negedge CLK);
        checks++;
        if (Grant !== 4'b0000 || Busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle: grant=%b busy=%b want 0000/0", Grant, Busy);
        end
    endtask

    task automatic test_single();
        bit ok;
        int k;
        mc[0] = 8'd3;
        mr[0] = 8'hFC;
        drive_bus();
        Req_Sig = 4'b0001;
        k = pick(m_ptr, Req_Sig);
        m_ptr = k;
        @(negedge CLK);
        checks++;
        if (Grant !== 4'(1 << k)) begin
            failures++;
            $display("FAIL single_grant: got %b want %b", Grant, 4'(1 << k));
        end
        checks++;
        if ({Mul_Start, Busy, Mul_Mcand, Mul_Mer} !== {2'b11, 8'd3, 8'hFC}) begin
            failures++;
            $display("FAIL single_start: start=%b busy=%b mcand=%h mer=%h want 1/1/03/fc", Mul_Start, Busy, Mul_Mcand, Mul_Mer);
        end
        wait_done(200, ok);
        checks++;
        if (!ok || Done_Sig !== 4'b0001 || Product !== 16'hFFF4 || Err_Sig !== 1'b0) begin
            failures++;
            $display("FAIL single_done: seen=%0d done=%b product=%h err=%b want 0001/fff4/0", ok, Done_Sig, Product, Err_Sig);
        end
        checks++;
        if (cyc != mdone_cyc + 1) begin
            failures++;
            $display("FAIL single_latency: done at cycle %0d want %0d", cyc, mdone_cyc + 1);
        end
        Req_Sig = '0;
        @(negedge CLK);
        checks++;
        if (Done_Sig !== 4'b0000 || Mul_Start !== 1'b0 || Grant !== 4'b0001) begin
            failures++;
            $display("FAIL single_gap: done=%b start=%b grant=%b want 0000/0/0001", Done_Sig, Mul_Start, Grant);
        end
        @(negedge CLK);
        checks++;
        if (Grant !== 4'b0000 || Busy !== 1'b0) begin
            failures++;
            $display("FAIL single_idle: grant=%b busy=%b want 0000/0", Grant, Busy);
        end
    endtask

    task automatic test_round_robin();
        bit ok;
        int k;
        RSTn = 1'b0;
        @(negedge CLK);
        RSTn = 1'b1;
        m_ptr = 3;
        for (int j = 0; j < 4; j++) begin
            mc[j] = 8'($urandom);
            mr[j] = 8'($urandom);
        end
        drive_bus();
        Req_Sig = 4'hF;
        for (int n = 0; n < 5; n++) begin
            wait_grant(50, ok);
            k = n % 4;
            m_ptr = k;
            checks++;
            if (!ok || Grant !== 4'(1 << k)) begin
                failures++;
                $display("FAIL rr_grant[%0d]: got %b want %b", n, Grant, 4'(1 << k));
            end
            if (n > 0) begin
                checks++;
                if (cyc != mdone_cyc + 4) begin
                    failures++;
                    $display("FAIL rr_back_to_back[%0d]: grant at cycle %0d want %0d", n, cyc, mdone_cyc + 4);
                end
            end
            wait_done(200, ok);
            checks++;
            if (!ok || Done_Sig !== 4'(1 << k) || Product !== ref_prod(mc[k], mr[k]) || Err_Sig !== 1'b0) begin
                failures++;
                $display("FAIL rr_done[%0d]: done=%b product=%h err=%b want %b/%h/0", n, Done_Sig, Product, Err_Sig, 4'(1 << k), ref_prod(mc[k], mr[k]));
            end
            if (n == 4) Req_Sig = '0;
            repeat (2) @(negedge CLK);
        end
    endtask

    task automatic test_operand_isolation();
        bit ok;
        bit bad;
        mc[2] = 8'h80;
        mr[2] = 8'hFF;
        drive_bus();
        Req_Sig = 4'b0100;
        wait_grant(20, ok);
        m_ptr = 2;
        checks++;
        if (!ok || Grant !== 4'b0100) begin
            failures++;
            $display("FAIL iso_grant2: got %b want 0100", Grant);
        end
        Req_Sig = 4'b0110;
        ok = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            mc[1] = 8'($urandom);
            mr[1] = 8'($urandom);
            drive_bus();
            @(negedge CLK);
            if (Done_Sig !== 4'b0000) ok = 1'b1;
            else if ({Mul_Mcand, Mul_Mer} !== 16'h80FF) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL iso_operands_held: mcand=%h mer=%h want 80/ff", Mul_Mcand, Mul_Mer);
        end
        checks++;
        if (!ok || Done_Sig !== 4'b0100 || Product !== 16'h0080 || Err_Sig !== 1'b0) begin
            failures++;
            $display("FAIL iso_done2: done=%b product=%h err=%b want 0100/0080/0", Done_Sig, Product, Err_Sig);
        end
        Req_Sig = 4'b0010;
        mc[1] = 8'($urandom);
        mr[1] = 8'($urandom);
        drive_bus();
        repeat (2) @(negedge CLK);
        wait_grant(20, ok);
        m_ptr = 1;
        checks++;
        if (!ok || Grant !== 4'b0010 || Mul_Mcand !== mc[1] || Mul_Mer !== mr[1]) begin
            failures++;
            $display("FAIL iso_grant1: grant=%b mcand=%h mer=%h want 0010/%h/%h", Grant, Mul_Mcand, Mul_Mer, mc[1], mr[1]);
        end
        wait_done(200, ok);
        checks++;
        if (!ok || Done_Sig !== 4'b0010 || Product !== ref_prod(mc[1], mr[1])) begin
            failures++;
            $display("FAIL iso_done1: done=%b product=%h want 0010/%h", Done_Sig, Product, ref_prod(mc[1], mr[1]));
        end
        Req_Sig = '0;
        repeat (2) @(negedge CLK);
    endtask

    task automatic test_timeout();
        bit ok;
        int k;
        int g;
        for (int j = 2; j < 4; j++) begin
            mc[j] = 8'($urandom_range(1, 100));
            mr[j] = 8'($urandom_range(1, 100));
        end
        drive_bus();
        mul_stub = 1'b1;
        Req_Sig = 4'b1100;
        k = pick(m_ptr, Req_Sig);
        m_ptr = k;
        wait_grant(20, ok);
        g = cyc;
        checks++;
        if (!ok || Grant !== 4'(1 << k)) begin
            failures++;
            $display("FAIL to_grant: got %b want %b", Grant, 4'(1 << k));
        end
        wait_done(TIMEOUT + 50, ok);
        checks++;
        if (!ok || cyc != g + TIMEOUT + 1) begin
            failures++;
            $display("FAIL to_latency: done at cycle %0d want %0d", cyc, g + TIMEOUT + 1);
        end
        checks++;
        if (Done_Sig !== 4'(1 << k) || Err_Sig !== 1'b1 || Product !== 16'h0000) begin
            failures++;
            $display("FAIL to_result: done=%b err=%b product=%h want %b/1/0000", Done_Sig, Err_Sig, Product, 4'(1 << k));
        end
        mul_stub = 1'b0;
        Req_Sig[k] = 1'b0;
        @(negedge CLK);
        checks++;
        if (Mul_Start !== 1'b0) begin
            failures++;
            $display("FAIL to_start_drop: got %b want 0", Mul_Start);
        end
        @(negedge CLK);
        checks++;
        if (Err_Sig !== 1'b0) begin
            failures++;
            $display("FAIL to_err_clear: got %b want 0", Err_Sig);
        end
        k = pick(m_ptr, Req_Sig);
        m_ptr = k;
        wait_grant(20, ok);
        checks++;
        if (!ok || Grant !== 4'(1 << k)) begin
            failures++;
            $display("FAIL to_next_grant: got %b want %b", Grant, 4'(1 << k));
        end
        wait_done(200, ok);
        checks++;
        if (!ok || Product !== ref_prod(mc[k], mr[k]) || Err_Sig !== 1'b0) begin
            failures++;
            $display("FAIL to_next_done: product=%h err=%b want %h/0", Product, Err_Sig, ref_prod(mc[k], mr[k]));
        end
        Req_Sig = '0;
        repeat (2) @(negedge CLK);
    endtask

    task automatic test_zero();
        bit ok;
        int low;
        mc[0] = 8'd0;
        mr[0] = 8'd0;
        mc[1] = 8'd127;
        mr[1] = 8'd0;
        drive_bus();
        Req_Sig = 4'b0011;
        wait_grant(20, ok);
        m_ptr = 0;
        checks++;
        if (!ok || Grant !== 4'b0001) begin
            failures++;
            $display("FAIL zero_grant0: got %b want 0001", Grant);
        end
        wait_done(200, ok);
        checks++;
        if (!ok || Product !== 16'h0000 || Err_Sig !== 1'b0) begin
            failures++;
            $display("FAIL zero_0x0: product=%h err=%b want 0000/0", Product, Err_Sig);
        end
        Req_Sig = 4'b0010;
        low = 0;
        ok = 1'b0;
        for (int i = 0; i < 10 && !ok; i++) begin
            @(negedge CLK);
            if (Grant === 4'b0010) ok = 1'b1;
            else if (Mul_Start === 1'b0) low++;
        end
        checks++;
        if (!ok || low < 1) begin
            failures++;
            $display("FAIL zero_start_gap: low cycles=%0d granted=%0d want >=1/1", low, ok);
        end
        wait_done(200, ok);
        checks++;
        if (!ok || Done_Sig !== 4'b0010 || Product !== 16'h0000 || Err_Sig !== 1'b0) begin
            failures++;
            $display("FAIL zero_127x0: done=%b product=%h err=%b want 0010/0000/0", Done_Sig, Product, Err_Sig);
        end
        m_ptr = 1;
        Req_Sig = '0;
        repeat (2) @(negedge CLK);
    endtask

    task automatic test_reset_mid_run();
        bit ok;
        mc[2] = 8'd5;
        mr[2] = 8'd7;
        drive_bus();
        Req_Sig = 4'b0100;
        wait_grant(20, ok);
        wait_done(200, ok);
        checks++;
        if (!ok || Product !== 16'h0023) begin
            failures++;
            $display("FAIL rst_pre_product: got %h want 0023", Product);
        end
        mc[3] = 8'($urandom);
        mr[3] = 8'($urandom);
        drive_bus();
        Req_Sig = 4'b1000;
        mul_stub = 1'b1;
        repeat (2) @(negedge CLK);
        wait_grant(20, ok);
        checks++;
        if (!ok || Grant !== 4'b1000) begin
            failures++;
            $display("FAIL rst_grant3: got %b want 1000", Grant);
        end
        repeat (3) @(negedge CLK);
        #2 RSTn = 1'b0;
        #1;
        checks++;
        if ({Grant, Done_Sig, Busy, Mul_Start, Err_Sig, Product} !== 27'b0) begin
            failures++;
            $display("FAIL rst_async: grant=%b done=%b busy=%b start=%b err=%b product=%h want all 0", Grant, Done_Sig, Busy, Mul_Start, Err_Sig, Product);
        end
        mc[0] = 8'($urandom);
        mr[0] = 8'($urandom);
        drive_bus();
        Req_Sig = 4'b1001;
        @(negedge CLK);
        RSTn = 1'b1;
        mul_stub = 1'b0;
        m_ptr = 3;
        @(negedge CLK);
        checks++;
        if (Grant !== 4'b0001) begin
            failures++;
            $display("FAIL rst_first_winner: got %b want 0001", Grant);
        end
        wait_done(200, ok);
        checks++;
        if (!ok || Done_Sig !== 4'b0001 || Product !== ref_prod(mc[0], mr[0])) begin
            failures++;
            $display("FAIL rst_done0: done=%b product=%h want 0001/%h", Done_Sig, Product, ref_prod(mc[0], mr[0]));
        end
        Req_Sig = 4'b1000;
        repeat (2) @(negedge CLK);
        wait_grant(20, ok);
        wait_done(200, ok);
        m_ptr = 3;
        checks++;
        if (!ok || Done_Sig !== 4'b1000 || Product !== ref_prod(mc[3], mr[3])) begin
            failures++;
            $display("FAIL rst_done3: done=%b product=%h want 1000/%h", Done_Sig, Product, ref_prod(mc[3], mr[3]));
        end
        Req_Sig = '0;
        repeat (2) @(negedge CLK);
    endtask

    task automatic test_random();
        bit ok;
        int k;
        logic [3:0] add;
        for (int n = 0; n < 24; n++) begin
            add = 4'($urandom_range(0, 15)) & ~Req_Sig;
            if ((Req_Sig | add) == 4'b0000) add = 4'(1 << $urandom_range(0, 3));
            for (int j = 0; j < 4; j++) if (add[j]) begin
                mc[j] = 8'($urandom);
                mr[j] = 8'($urandom);
            end
            drive_bus();
            Req_Sig = Req_Sig | add;
            k = pick(m_ptr, Req_Sig);
            m_ptr = k;
            wait_grant(20, ok);
            checks++;
            if (!ok || Grant !== 4'(1 << k)) begin
                failures++;
                $display("FAIL rand_grant[%0d]: req=%b got %b want %b", n, Req_Sig, Grant, 4'(1 << k));
            end
            wait_done(200, ok);
            checks++;
            if (!ok || Done_Sig !== 4'(1 << k) || Product !== ref_prod(mc[k], mr[k]) || Err_Sig !== 1'b0) begin
                failures++;
                $display("FAIL rand_done[%0d]: done=%b product=%h err=%b want %b/%h/0", n, Done_Sig, Product, Err_Sig, 4'(1 << k), ref_prod(mc[k], mr[k]));
            end
            Req_Sig[k] = 1'b0;
            repeat (2) @(negedge CLK);
        end
        Req_Sig = '0;
        repeat (2) @(negedge CLK);
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_operand_isolation();
        test_timeout();
        test_zero();
        test_reset_mid_run();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end
endmodule
